conv_window_feeder: RTL
=======================

# conv_window_feeder

Parametrised successor to the convolution-layer input interface: buffers the last KERNEL_SIZE image rows for each of CHANNELS input channels in a circular line buffer. On command it streams every kernel-position window slice to the conv array, ARRAY_SIZE lanes at a time, with a configurable stride, then one bias slice. It sits between the external-memory read port and the conv kernel array and is sequenced by the layer controller through a cmd/ack handshake. Compared with the single-channel interface, it adds multi-channel operation, stride, a valid-qualified memory read, row-rotation reuse, and an error/abort path.

## Interface
- DATA_WIDTH, 32, word width (float32)
- KERNEL_SIZE, 3, kernel side K
- IMAGE_SIZE, 8, image row length W
- STRIDE, 1, horizontal stride S
- ARRAY_SIZE, 6, output lanes; must equal (W-K)/S+1
- CHANNELS, 2, input channels C
- ADDR_WIDTH, 16, external address width
- BIAS_VALUE, 32'h3F800000, lane value in bias slice
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  low forces IDLE next cycle
- cmd  in  2  0 NONE, 1 SHIFT, 2 LOAD, 3 CLEAR
- ack  out  2  0 IDLE, 1 SHIFT_FIN, 2 LOAD_FIN, 3 ERR; single-cycle pulses
- ext_rd_en  out  1  read request, high throughout LOAD
- ext_addr  out  ADDR_WIDTH  address of the next word to accept
- data_in  in  DATA_WIDTH  external read data
- data_in_valid  in  1  data_in carries a word
- data_out  out  ARRAY_SIZE*DATA_WIDTH  lane i at bits [(i+1)*DW-1 : i*DW]
- data_out_valid  out  1  data_out holds a slice
- data_out_bias  out  1  current slice is the bias slice
- rows_ready  out  1  K valid rows buffered

## Operation
- States: IDLE, LOAD, SHIFT, BIAS. Only one clock and one reset.
- Buffer: C×K×W words. Write-row pointer wr_row (0..K-1) points at the oldest row. rows_valid counter saturates at K. rows_ready = (rows_valid==K).
- IDLE transitions:
  - cmd LOAD -> LOAD.
  - cmd SHIFT with rows_ready -> SHIFT.
  - cmd SHIFT without rows_ready -> stay IDLE, ack=ERR.
  - cmd CLEAR -> clears ext_addr, rows_valid and wr_row; stays IDLE.
- LOAD:
  - Accepts one word per cycle in which data_in_valid=1, channel-major (channel 0 cols 0..W-1, then channel 1, ...). Each word is written to buffer[ch][wr_row][col].
  - ext_addr increments per accepted word. data_in_valid outside LOAD is ignored.
  - When the last word (ch=C-1, col=W-1) is accepted: wr_row <= (wr_row+1) mod K, rows_valid++ (saturating), row_base <= ext_addr+1, state -> IDLE, ack=LOAD_FIN.
  - cmd is ignored during LOAD.
- SHIFT:
  - Iterates ch 0..C-1 (outer), r 0..K-1, s 0..K-1 (inner): C·K·K cycles.
  - Slot is (wr_row+r) mod K, so r=0 is the oldest row.
  - Lane i is loaded with buffer[ch][slot][i*S+s].
  - After the last index -> BIAS.
  - cmd is ignored during SHIFT.
- BIAS (1 cycle):
  - All lanes are loaded with BIAS_VALUE, and ack=SHIFT_FIN.
  - Next state: cmd LOAD -> LOAD, cmd SHIFT (rows_ready) -> SHIFT, otherwise IDLE.
- enable low:
  - The state goes to IDLE, and the ch/r/s/col counters clear.
  - A partially loaded row is discarded: ext_addr <= row_base, and rows_valid and wr_row are unchanged.
  - No ack is produced.
- A repeated LOAD after the buffer is full overwrites the oldest row (sliding window down the image).

## Timing
- All outputs are registered. rst clears state to IDLE and every counter, pointer, ext_addr and row_base to 0.
- Reset values: ack=0, ext_rd_en=0, data_out=0, data_out_valid=0, data_out_bias=0, rows_ready=0. Buffer contents are don't-care.
- ext_rd_en=1 in every cycle where the state is LOAD.
- A word accepted in cycle t is readable by a SHIFT that starts in cycle t+1 or later.
- Slice latency: a SHIFT/BIAS cycle at t gives data_out and data_out_valid at t+1. data_out=0 whenever data_out_valid=0.
- ack timing: ack=LOAD_FIN in the cycle after the last word is accepted. ack=SHIFT_FIN in the same cycle as the bias slice output (t+1 of the BIAS state). ack=ERR in the cycle after the rejected command.
- Back-to-back: BIAS with cmd SHIFT gives a contiguous stream of C·K·K+1 valid slices with no bubble.
- rst mid-LOAD/SHIFT: the next cycle shows IDLE with reset values.

## Test plan
Parameters K=3, W=8, S=1, C=2, ARRAY=6; data_in = ext_addr.
- Fill: CLEAR, then 3×LOAD with data_in_valid held high -> each LOAD_FIN arrives 16 cycles after entry, ext_addr=48 at the end, rows_ready=1 after the third.
- SHIFT: 18 valid slices then 1 bias slice, SHIFT_FIN with the bias slice. The first slice has lanes 0..5 = 0..5. The slice for ch1,r0,s2 has lanes 10..15. The bias slice is all 3F800000.
- Stall: during LOAD, data_in_valid toggles 1,0,1,0 -> only valid words are written, ext_addr advances only on valid words, buffer contents are identical to the unstalled case.
- Rotation: a 4th LOAD (addresses 48..63), then SHIFT -> the r0 slice for ch0 starts at value 16, and the r2 slice for ch0 starts at value 48.
- Errors: SHIFT after CLEAR -> ack=3 for one cycle, state stays IDLE, data_out_valid=0. Dropping enable after 5 words of a LOAD -> ext_addr rewinds to row_base, and rows_valid is unchanged.
- Reset: rst asserted mid-SHIFT -> the next cycle has all outputs at reset values, and a subsequent SHIFT gives ERR.

Source files
------------

// File: rtl/conv_window_feeder.sv
// Circular K-row line buffer per input channel. On SHIFT it streams every
// kernel-position window slice (stride-spaced lanes), then one bias slice.
module conv_window_feeder #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    KERNEL_SIZE = 3,
   parameter int                    IMAGE_SIZE  = 8,
   parameter int                    STRIDE      = 1,
   parameter int                    ARRAY_SIZE  = 6,
   parameter int                    CHANNELS    = 2,
   parameter int                    ADDR_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] BIAS_VALUE  = 32'h3F800000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic [1:0]                       cmd,
   output logic [1:0]                       ack,
   output logic                             ext_rd_en,
   output logic [ADDR_WIDTH-1:0]            ext_addr,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             data_in_valid,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_out,
   output logic                             data_out_valid,
   output logic                             data_out_bias,
   output logic                             rows_ready
);

   localparam int CH_W  = (CHANNELS > 1)    ? $clog2(CHANNELS)    : 1;
   localparam int RW_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int COL_W = (IMAGE_SIZE > 1)  ? $clog2(IMAGE_SIZE)  : 1;
   localparam int RV_W  = $clog2(KERNEL_SIZE + 1);

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_SHIFT = 2'd1;
   localparam logic [1:0] CMD_LOAD  = 2'd2;
   localparam logic [1:0] CMD_CLEAR = 2'd3;

   localparam logic [1:0] ACK_IDLE      = 2'd0;
   localparam logic [1:0] ACK_SHIFT_FIN = 2'd1;
   localparam logic [1:0] ACK_LOAD_FIN  = 2'd2;
   localparam logic [1:0] ACK_ERR       = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_BIAS} state_t;

   state_t                     state;
   logic [CH_W-1:0]            ch;
   logic [RW_W-1:0]            r_cnt;
   logic [RW_W-1:0]            s_cnt;
   logic [COL_W-1:0]           col;
   logic [RW_W-1:0]            wr_row;
   logic [RV_W-1:0]            rows_valid;
   logic [ADDR_WIDTH-1:0]      row_base;

   logic [DATA_WIDTH-1:0]      buf_mem [CHANNELS][KERNEL_SIZE][IMAGE_SIZE];

   logic [RW_W:0]              slot_sum;
   logic [RW_W-1:0]            slot;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] window;
   logic                       wr_en;
   logic                       last_word;
   logic                       last_index;

   // wr_row is the oldest row, so r=0 of a window maps onto it.
   assign slot_sum = {1'b0, wr_row} + {1'b0, r_cnt};
   assign slot     = (slot_sum >= (RW_W+1)'(KERNEL_SIZE))
                   ? RW_W'(slot_sum - (RW_W+1)'(KERNEL_SIZE))
                   : slot_sum[RW_W-1:0];

   assign last_word  = (ch == CH_W'(CHANNELS-1)) && (col == COL_W'(IMAGE_SIZE-1));
   assign last_index = (ch == CH_W'(CHANNELS-1)) && (r_cnt == RW_W'(KERNEL_SIZE-1))
                    && (s_cnt == RW_W'(KERNEL_SIZE-1));

   assign wr_en = enable && (state == S_LOAD) && data_in_valid;

   for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
      assign window[g*DATA_WIDTH +: DATA_WIDTH] =
         buf_mem[ch][slot][COL_W'(g*STRIDE) + COL_W'(s_cnt)];
   end

   // Line buffer storage carries no reset; contents are meaningless until loaded.
   always_ff @(posedge clk) begin
      if (wr_en)
         buf_mem[ch][wr_row][col] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         ch             <= '0;
         r_cnt          <= '0;
         s_cnt          <= '0;
         col            <= '0;
         wr_row         <= '0;
         rows_valid     <= '0;
         row_base       <= '0;
         ext_addr       <= '0;
         ext_rd_en      <= 1'b0;
         ack            <= ACK_IDLE;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_bias  <= 1'b0;
         rows_ready     <= 1'b0;
      end else begin
         ack            <= ACK_IDLE;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_bias  <= 1'b0;

         if (!enable) begin
            // Abort: drop any half-written row and rewind the read address.
            state     <= S_IDLE;
            ext_rd_en <= 1'b0;
            ch        <= '0;
            r_cnt     <= '0;
            s_cnt     <= '0;
            col       <= '0;
            if (state == S_LOAD)
               ext_addr <= row_base;
         end else begin
            case (state)
               S_IDLE: begin
                  case (cmd)
                     CMD_NONE: ;
                     CMD_LOAD: begin
                        state     <= S_LOAD;
                        ext_rd_en <= 1'b1;
                     end
                     CMD_SHIFT: begin
                        if (rows_ready)
                           state <= S_SHIFT;
                        else
                           ack <= ACK_ERR;
                     end
                     CMD_CLEAR: begin
                        ext_addr   <= '0;
                        row_base   <= '0;
                        rows_valid <= '0;
                        rows_ready <= 1'b0;
                        wr_row     <= '0;
                     end
                  endcase
               end

               S_LOAD: begin
                  if (data_in_valid) begin
                     ext_addr <= ext_addr + 1'b1;
                     if (last_word) begin
                        col       <= '0;
                        ch        <= '0;
                        wr_row    <= (wr_row == RW_W'(KERNEL_SIZE-1)) ? '0 : wr_row + 1'b1;
                        if (rows_valid != RV_W'(KERNEL_SIZE))
                           rows_valid <= rows_valid + 1'b1;
                        rows_ready <= (rows_valid >= RV_W'(KERNEL_SIZE-1));
                        row_base   <= ext_addr + 1'b1;
                        state      <= S_IDLE;
                        ext_rd_en  <= 1'b0;
                        ack        <= ACK_LOAD_FIN;
                     end else if (col == COL_W'(IMAGE_SIZE-1)) begin
                        col <= '0;
                        ch  <= ch + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end

               S_SHIFT: begin
                  data_out       <= window;
                  data_out_valid <= 1'b1;
                  if (s_cnt == RW_W'(KERNEL_SIZE-1)) begin
                     s_cnt <= '0;
                     if (r_cnt == RW_W'(KERNEL_SIZE-1)) begin
                        r_cnt <= '0;
                        ch    <= (ch == CH_W'(CHANNELS-1)) ? '0 : ch + 1'b1;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
                  if (last_index)
                     state <= S_BIAS;
               end

               S_BIAS: begin
                  data_out       <= {ARRAY_SIZE{BIAS_VALUE}};
                  data_out_valid <= 1'b1;
                  data_out_bias  <= 1'b1;
                  ack            <= ACK_SHIFT_FIN;
                  // Accepting the next command here keeps the slice stream gap-free.
                  if (cmd == CMD_LOAD) begin
                     state     <= S_LOAD;
                     ext_rd_en <= 1'b1;
                  end else if (cmd == CMD_SHIFT && rows_ready) begin
                     state <= S_SHIFT;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule
